multicycle_controller: RTL
==========================

# multicycle_controller

Sequencing controller for the multicycle RISC-V core. It is a Moore state machine that steps the shared datapath (one ALU, one unified instruction/data memory port, register file, PC/IR/ALUOut/Data registers) through fetch, decode, execute, memory and writeback for LOAD, STORE, R-type, I-type ALU and B-type (beq/bne/blt) instructions. A ready/request handshake on the memory port lets the core stall on slow memory. A wait-timeout aborts a hung access.

## Interface
- MEM_TIMEOUT, 15: max cycles an access may wait for mem_ready before abort; legal range 1..255.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- ZF, SF  in  1 each  ALU zero / sign flags, combinational from current ALU result
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  store qualifier, valid only with mem_req
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load IR and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register-file write enable
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rd1
- ALUSrcB  out  2  00 = rd2, 01 = imm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALU result
- ImmSrc  out  2  00 = I, 01 = S, 10 = B
- ALUControl  out  3  0 add, 1 sll, 2 sub, 4 xor, 5 srl, 6 or, 7 and
- instr_done  out  1  one-cycle pulse in the final state of each retired instruction
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode
- bus_err  out  1  one-cycle pulse on access timeout

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- FETCH:
  - Outputs: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite and PCWrite are asserted only in the cycle mem_ready=1; the FSM then moves to DECODE.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add. This computes the branch target into ALUOut.
  - Next state: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH.
  - Any other opcode: pulse illegal, go to FETCH, no writes.
- MEMADR:
  - Outputs: ALUSrcA=10, ALUSrcB=01, add. ImmSrc=00 for a load, 01 for a store.
  - Next state: MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req=1, AdrSrc=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done. Go to FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. On mem_ready, pulse instr_done and go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, R-type ALU decode. Go to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, I-type ALU decode. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done. Go to FETCH.
- BRANCH:
  - Outputs: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, instr_done.
  - PCWrite = ZF for funct3 000, ~ZF for 001, SF for 100, 0 for any other funct3. Go to FETCH.
- R-type ALU decode ({funct3,funct7_5}):
  - 000_0 -> 0; 000_1 -> 2; 001_0 -> 1; 100_0 -> 4.
  - 101_0 -> 5; 110_0 -> 6; 111_0 -> 7; anything else -> 0.
- I-type ALU decode: identical, except funct3=000 always decodes to add, whatever funct7_5 is.
- Timeout:
  - An 8-bit wait counter clears on entry to FETCH, MEMREAD or MEMWRITE, and increments each cycle mem_req=1 and mem_ready=0.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0, pulse bus_err and go to FETCH.
  - The aborting cycle asserts no IRWrite, PCWrite, RegWrite or MemWrite.
  - A FETCH timeout re-enters FETCH and retries at the unchanged PC.

## Timing
- While rst=1 all outputs are forced to 0. The first cycle after reset release is FETCH with mem_req=1.
- All outputs are combinational from the state register plus op/funct3/funct7_5/ZF/SF/mem_ready. There is no output register.
- A response is accepted in the same cycle: mem_ready is sampled in the cycle mem_req=1.
- mem_ready while mem_req=0 is ignored.
- Zero-wait latency: load 5 cycles; store, R-type and I-type 4; branch 3. Each memory wait cycle adds 1.
- rst asserted mid-instruction: the next state is FETCH and any pending write is dropped.
- mem_ready in the same cycle the counter reaches MEM_TIMEOUT: ready wins, and the access completes normally.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - Opcode constants.
  - The state enum.
  - ALUControl codes.
  - The ALUSrcA/ALUSrcB/ResultSrc/ImmSrc encodings.
- Sub-module alu_decoder is combinational: inputs ALUOp[1:0], funct3, funct7_5, is_rtype; output ALUControl. It is instantiated once.
- The FSM, wait counter and branch-condition logic live in multicycle_controller.

## Test plan
- ADD R-type (op 0110011, funct3 000, funct7_5 0) with mem_ready tied high -> FETCH, DECODE, EXECR, ALUWB; ALUControl=0 in EXECR; RegWrite and instr_done pulse in cycle 4.
- LOAD with mem_ready low for 3 cycles in MEMREAD -> stays in MEMREAD 4 cycles; MEMWB has RegWrite=1 and ResultSrc=01; 8 cycles total.
- BNE with ZF=0 -> PCWrite=1 in BRANCH; BLT with SF=0 -> PCWrite=0; funct3=010 -> PCWrite=0; each retires in 3 cycles.
- MEMWRITE with mem_ready held low and MEM_TIMEOUT=15 -> bus_err pulses after 15 wait cycles; MemWrite drops; FSM returns to FETCH; no instr_done.
- Opcode 1111111 -> illegal pulses in DECODE; FETCH follows with no RegWrite or PCWrite.
- rst asserted during MEMWB -> RegWrite=0 in that cycle; FETCH with mem_req=1 the cycle after rst falls.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: opcodes, FSM states,
// ALU operation codes and datapath mux selects.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SLL = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;
  localparam logic [2:0] ALU_OR  = 3'd6;
  localparam logic [2:0] ALU_AND = 3'd7;

  // ALUOp from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus funct3/funct7_5 onto an ALUControl code.
// Unsupported function encodings fall back to add.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_rtype,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case ({funct3, funct7_5})
          4'b000_0: ALUControl = ALU_ADD;
          // immediate forms have no subtract; bit 30 is immediate data there
          4'b000_1: ALUControl = is_rtype ? ALU_SUB : ALU_ADD;
          4'b001_0: ALUControl = ALU_SLL;
          4'b100_0: ALUControl = ALU_XOR;
          4'b101_0: ALUControl = ALU_SRL;
          4'b110_0: ALUControl = ALU_OR;
          4'b111_0: ALUControl = ALU_AND;
          default:  ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle RISC-V core, with memory
// ready/request handshake, access wait-timeout and branch resolution.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_FETCH    | read instruction at PC, PC+4 -> PC, load IR/OldPC on ready
// S_DECODE   | branch target OldPC+immB -> ALUOut, dispatch on opcode
// S_MEMADR   | rd1+imm -> ALUOut (load I-imm, store S-imm)
// S_MEMREAD  | read data at ALUOut, wait for ready
// S_MEMWB    | Data -> rd, retire load
// S_MEMWRITE | write rd2 at ALUOut, retire store on ready
// S_EXECR    | rd1 op rd2 -> ALUOut
// S_EXECI    | rd1 op immI -> ALUOut
// S_ALUWB    | ALUOut -> rd, retire ALU instruction
// S_BRANCH   | rd1-rd2 sets flags, ALUOut -> PC if taken, retire branch
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       ZF,
  input  logic       SF,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic       mem_access;
  logic       waiting;
  logic       timeout;
  logic       branch_taken;
  logic [1:0] alu_op;
  logic       is_rtype;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      // any state entry (including a FETCH retry) restarts the wait count
      if ((state_next != state) || timeout) begin
        wait_cnt <= '0;
      end else if (waiting) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  assign mem_access = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign waiting    = mem_access && !mem_ready && !rst;
  assign timeout    = waiting && (wait_cnt == TIMEOUT_CNT);

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      F3_BEQ:  branch_taken = ZF;
      F3_BNE:  branch_taken = !ZF;
      F3_BLT:  branch_taken = SF;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    ResultSrc  = RES_ALUOUT;
    ImmSrc     = IMM_I;
    instr_done = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    alu_op     = ALUOP_ADD;
    is_rtype   = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          bus_err    = 1'b1;
          state_next = S_FETCH;
        end
      end

      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
        if (is_mem_op(op)) begin
          state_next = S_MEMADR;
        end else begin
          case (op)
            OP_RTYPE:  state_next = S_EXECR;
            OP_ITYPE:  state_next = S_EXECI;
            OP_BRANCH: state_next = S_BRANCH;
            default: begin
              illegal    = 1'b1;
              state_next = S_FETCH;
            end
          endcase
        end
      end

      S_MEMADR: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = (op == OP_STORE) ? IMM_S : IMM_I;
        state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) begin
          state_next = S_MEMWB;
        end else if (timeout) begin
          bus_err    = 1'b1;
          state_next = S_FETCH;
        end
      end

      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end

      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = !timeout;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else if (timeout) begin
          bus_err    = 1'b1;
          state_next = S_FETCH;
        end
      end

      S_EXECR: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_RD2;
        alu_op     = ALUOP_FUNCT;
        is_rtype   = 1'b1;
        state_next = S_ALUWB;
      end

      S_EXECI: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_I;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end

      S_ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_RD2;
        alu_op     = ALUOP_SUB;
        ResultSrc  = RES_ALUOUT;
        PCWrite    = branch_taken;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end

      default: state_next = S_FETCH;
    endcase

    // reset masks every output so no write can slip through mid-instruction
    if (rst) begin
      state_next = S_FETCH;
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RD2;
      ResultSrc  = RES_ALUOUT;
      ImmSrc     = IMM_I;
      instr_done = 1'b0;
      illegal    = 1'b0;
      bus_err    = 1'b0;
      alu_op     = ALUOP_ADD;
      is_rtype   = 1'b0;
    end
  end

  alu_decoder u_alu_decoder (
    .ALUOp      (alu_op),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .is_rtype   (is_rtype),
    .ALUControl (ALUControl)
  );

endmodule
